// File: rtl/fetch_prefetch_stage.sv
// fetch_prefetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC and a word-addressed instruction memory that the bench can load.
// Fetched words are queued in a small prefetch FIFO so decode can stall
// without losing fetches. A taken branch from the memory stage flushes the
// FIFO and redirects the PC.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   load_we/addr/data program-load write port into imem (pauses fetch)
//   redirect_valid/pc taken branch: flush FIFO and set PC (word address)
//   out_valid/ready   handshake to decode
//   out_instr         head instruction (0 while empty)
//   out_pc_plus1      head PC + 1 (0 while empty)
//   fetch_pc          current fetch PC
//   occupancy         FIFO entry count
//
// Optional feature macro: FETCH_STATS_EN adds saturating stall_cycles and
// flush_count outputs.

module fetch_prefetch_stage #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_we,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [DATA_W-1:0]         load_data,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_instr,
  output logic [31:0]               out_pc_plus1,
  output logic [31:0]               fetch_pc,
  output logic [$clog2(DEPTH):0]    occupancy
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]               stall_cycles,
  output logic [15:0]               flush_count
`endif
);

  localparam int unsigned MEM_WORDS = 2 ** ADDR_W;
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  logic [DATA_W-1:0] imem [MEM_WORDS];

  logic [DATA_W-1:0] fifo_instr_q [DEPTH];
  logic [DATA_W-1:0] fifo_instr_d [DEPTH];
  logic [31:0]       fifo_pcp1_q  [DEPTH];
  logic [31:0]       fifo_pcp1_d  [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic [31:0]       out_pcp1_q, out_pcp1_d;

  logic              pop_c;
  logic              push_c;
  logic [DATA_W-1:0] imem_rdata_c;

`ifdef FETCH_STATS_EN
  logic [15:0]       stall_q, stall_d;
  logic [15:0]       flush_q, flush_d;
`endif

  // Program-load port; a load during reset is ignored
  always_ff @(posedge clk) begin
    if (rst_n && load_we) begin
      imem[load_addr] <= load_data;
    end
  end

  // Fetch address wraps modulo MEM_WORDS via the low PC bits
  assign imem_rdata_c = imem[pc_q[ADDR_W-1:0]];

  assign pop_c  = out_valid_q & out_ready;
  assign push_c = !redirect_valid & !load_we &
                  ((count_q < CNT_W'(DEPTH)) | pop_c);

  // Next-state for PC, FIFO storage/pointers and registered head outputs
  always_comb begin
    fifo_instr_d = fifo_instr_q;
    fifo_pcp1_d  = fifo_pcp1_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    pc_d         = pc_q;

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        fifo_instr_d[wr_ptr_q] = imem_rdata_c;
        fifo_pcp1_d[wr_ptr_q]  = pc_q + 32'd1;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        pc_d                   = pc_q + 32'd1;
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Head is registered from post-update storage, so no memory bypass exists
    out_valid_d = (count_d != '0);
    out_instr_d = out_valid_d ? fifo_instr_d[rd_ptr_d] : '0;
    out_pcp1_d  = out_valid_d ? fifo_pcp1_d[rd_ptr_d]  : '0;
  end

`ifdef FETCH_STATS_EN
  // Saturating performance counters
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (redirect_valid && (flush_q != 16'hFFFF)) begin
      flush_d = flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

  // State registers; FIFO payload needs no reset since count gates it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pc_q        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pcp1_q  <= '0;
    end else begin
      fifo_instr_q <= fifo_instr_d;
      fifo_pcp1_q  <= fifo_pcp1_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pc_q         <= pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pcp1_q   <= out_pcp1_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc_plus1 = out_pcp1_q;
  assign fetch_pc     = pc_q;
  assign occupancy    = count_q;

endmodule
